multdiv_sequencer: RTL
======================

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 The block SHALL provide these ports, clock and reset first:
REQ-002 clock  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset; sampled on the rising edge of clock.
REQ-004 ctrl_MULT  in  1  one-cycle pulse; starts a multiply.
REQ-005 ctrl_DIV  in  1  one-cycle pulse; starts a divide.
REQ-006 divisor_zero  in  1  datapath flag: divisor operand equals 0; valid in the LOAD cycle.
REQ-007 mult_ovf  in  1  datapath flag: product does not fit in 32 bits; valid in the DONE cycle.
REQ-008 load  out  1  datapath captures operands and clears its product/remainder registers.
REQ-009 step  out  1  datapath performs one shift/add (multiply) or shift/subtract/restore (divide) iteration.
REQ-010 op_div  out  1  0 = multiply path selected, 1 = divide path selected.
REQ-011 count  out  6  iteration index of the current step, 0..31.
REQ-012 busy  out  1  high in LOAD, RUN and DONE.
REQ-013 data_resultRDY  out  1  one-cycle pulse; the datapath result is valid.
REQ-014 data_exception  out  1  qualified by data_resultRDY; divide by zero or multiply overflow.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, LOAD, RUN, DONE.
REQ-016 In IDLE, a ctrl pulse SHALL cause the next state to be LOAD; op_div SHALL be registered as ctrl_DIV && !ctrl_MULT.
REQ-017 If ctrl_MULT and ctrl_DIV are high in the same cycle, multiply SHALL win.
REQ-018 In LOAD, load SHALL be 1 for exactly one cycle, count SHALL be cleared to 0, and the next state SHALL be RUN.
REQ-019 In RUN, step SHALL be 1 every cycle and count SHALL increment by 1 per cycle; when count == 31, the next state SHALL be DONE.
REQ-020 count SHALL NOT wrap in RUN.
REQ-021 In DONE, data_resultRDY SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-022 Latency: with a pulse at cycle t, LOAD is at t+1, RUN spans t+2..t+33 (32 steps), and data_resultRDY is at t+34.
REQ-023 A ctrl pulse in LOAD or RUN SHALL abort the current operation: the next state SHALL be LOAD with the new op_div, and no data_resultRDY SHALL be issued for the aborted operation.
REQ-024 A ctrl pulse in DONE SHALL still assert data_resultRDY in that cycle; the next state SHALL be LOAD.
REQ-025 For a divide, divisor_zero SHALL be latched in the LOAD cycle into a sticky flag; data_exception in DONE SHALL equal that flag.
REQ-026 For a multiply, data_exception in DONE SHALL equal mult_ovf.
REQ-027 data_exception SHALL be 0 whenever data_resultRDY is 0.
REQ-028 load, step and data_resultRDY SHALL be mutually exclusive.
REQ-029 load, step and data_resultRDY SHALL be decoded from the registered state only; they SHALL NOT be combinational from the ctrl inputs.

Reset
REQ-030 While reset = 1 at a rising edge: state SHALL become IDLE; count, op_div and the sticky divide-by-zero flag SHALL become 0; load, step, busy, data_resultRDY and data_exception SHALL all be 0.
REQ-031 Reset SHALL take priority over any simultaneous ctrl pulse.
REQ-032 Reset during RUN SHALL discard the operation with no data_resultRDY.

Configuration
REQ-033 Macro DIV_ZERO_EARLY_EN, when defined: a divide with divisor_zero = 1 in LOAD SHALL go directly LOAD -> DONE, skip RUN (no step pulses), and assert data_resultRDY = 1 and data_exception = 1 at t+2.
REQ-034 Macro DIV_ZERO_EARLY_EN, when undefined: a divide-by-zero SHALL run all 32 steps and report data_exception = 1 at t+34.
REQ-035 Macro DIV_ZERO_EARLY_EN SHALL have no effect on multiply behaviour.

Verification
REQ-036 Bench: ctrl_MULT pulse at cycle 10, mult_ovf = 0 -> load at 11; step at 12..43 with count 0..31; data_resultRDY = 1 and data_exception = 0 at 44 only.
REQ-037 Bench: ctrl_DIV pulse at 10, divisor_zero = 1 -> with macro: data_resultRDY = 1, data_exception = 1 at 12, zero step pulses; without macro: data_resultRDY = 1, data_exception = 1 at 44.
REQ-038 Bench: ctrl_MULT at 10, then ctrl_DIV at 20 (count = 8) -> load at 21 with op_div = 1; data_resultRDY only at 54; no data_resultRDY at 44.
REQ-039 Bench: ctrl_MULT and ctrl_DIV both high at 10 -> op_div = 0 at 11; normal multiply completion at 44.
REQ-040 Bench: reset at 25 during RUN -> state IDLE at 26 with all outputs 0; a later ctrl_DIV at 30 gives data_resultRDY at 64.
REQ-041 Bench: ctrl_DIV pulse coincident with DONE at 44 -> data_resultRDY = 1 at 44, load at 45, next data_resultRDY at 78.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
// Control sequencer for a 32-step shift/add multiplier and
// shift/subtract/restore divider. It owns the IDLE -> LOAD -> RUN -> DONE
// sequence, the 0..31 iteration index, the operation select and the
// exception qualification. The datapath itself lives elsewhere.
//
// Build option: define DIV_ZERO_EARLY_EN to short-circuit a divide whose
// divisor is zero straight from LOAD to DONE, skipping all 32 steps.
// When it is undefined, a divide-by-zero runs the full sequence.
// Multiply behaviour does not depend on the macro.

module multdiv_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       ctrl_MULT,
    input  logic       ctrl_DIV,
    input  logic       divisor_zero,
    input  logic       mult_ovf,
    output logic       load,
    output logic       step,
    output logic       op_div,
    output logic [5:0] count,
    output logic       busy,
    output logic       data_resultRDY,
    output logic       data_exception
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'd31;

    state_t     state_q, state_d;
    logic [5:0] count_q, count_d;
    logic       op_div_q, op_div_d;
    logic       div_zero_q, div_zero_d;

    // Any ctrl pulse starts a new operation, whatever the current state.
    logic start;
    assign start = ctrl_MULT | ctrl_DIV;

    // State, iteration index, operation select and sticky divide-by-zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= 6'd0;
            op_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_div_q   <= op_div_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Next-state logic; a ctrl pulse in any state (re)starts in LOAD.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_div_d   = op_div_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end

            LOAD: begin
                // The datapath flag is only meaningful in this cycle, so
                // hold it for the DONE-cycle exception.
                div_zero_d = divisor_zero;
                if (start) begin
                    state_d = LOAD;
                end else begin
`ifdef DIV_ZERO_EARLY_EN
                    if (op_div_q && divisor_zero) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end
            end

            RUN: begin
                if (start) begin
                    state_d = LOAD;
                end else if (count_q == LAST_STEP) begin
                    // Index stays at 31 rather than wrapping.
                    state_d = DONE;
                end else begin
                    count_d = count_q + 6'd1;
                end
            end

            DONE: begin
                // The finished result is still reported this cycle even if
                // a new operation is being requested.
                if (start) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Common to every accepted pulse: select the path, multiply wins a tie,
        // and restart the iteration index.
        if (start) begin
            op_div_d = ctrl_DIV && !ctrl_MULT;
            count_d  = 6'd0;
        end
    end

    // Datapath strobes come from the registered state only.
    assign load           = (state_q == LOAD);
    assign step           = (state_q == RUN);
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE);
    assign op_div         = op_div_q;
    assign count          = count_q;

    // Exception is qualified by the result strobe.
    assign data_exception = (state_q == DONE) &&
                            (op_div_q ? div_zero_q : mult_ovf);

    // Structural invariants of the sequencer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert ($onehot0({load, step, data_resultRDY}))
                else $error("strobes not mutually exclusive");
            assert (count_q <= LAST_STEP)
                else $error("iteration index out of range");
        end
    end

endmodule
